// File: rtl/mips_mc_ctrl_if.sv
// Control bus between the multicycle sequencer and the datapath/memory.
//   master : the sequencer (mips_mc_ctrl) - reads opcode/flags/mem_ready,
//            drives every datapath control and the debug state.
//   slave  : the datapath / memory side - the mirror image.
interface mips_mc_ctrl_if;
  logic [5:0] opcode;
  logic       alu_zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [5:0] alu_op;
  logic       illegal_op;
  logic       mem_err;
  logic       instr_done;
  logic [3:0] state;

  modport master (
    input  opcode, alu_zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op,
           mem_err, instr_done, state
  );

  modport slave (
    output opcode, alu_zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op,
           mem_err, instr_done, state
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control sequencer.
// Steps each instruction through fetch / decode / execute / memory /
// write-back and drives the datapath controls as Moore outputs decoded from
// the state register (ir_write, pc_write, instr_done and mem_err additionally
// qualify on mem_ready / alu_zero inside their state).
// Ports:
//   clk   - clock, all state on the rising edge
//   rst_n - synchronous active-low reset; also forces every output to 0
//   bus   - mips_mc_ctrl_if.master: opcode, alu_zero, mem_ready in;
//           memory, PC, register-file, ALU controls and debug state out.
// A watchdog aborts a memory access (fetch, load or store) that sees no
// mem_ready for MEM_TIMEOUT consecutive cycles; MEM_TIMEOUT = 0 disables it.
module mips_mc_ctrl #(
  parameter logic [5:0]  ALUOP_ADD   = 6'h08,
  parameter logic [5:0]  ALUOP_SUB   = 6'h04,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  mips_mc_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXE    = 4'd6,
    R_WB     = 4'd7,
    I_EXE    = 4'd8,
    I_WB     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    ILLEGAL  = 4'd12
  } state_t;

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          in_mem;
  logic          timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign in_mem  = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
  // mem_ready on the expiry cycle wins: the timeout is qualified by !mem_ready.
  assign timeout = (MEM_TIMEOUT != 0) && in_mem && !bus.mem_ready && (wait_q == TO_LAST);

  // Count consecutive stalled cycles of one access; any state change,
  // completion or expiry restarts the count (expiry in FETCH stays in FETCH,
  // hence the explicit clear on timeout).
  always_comb begin
    wait_d = '0;
    if (in_mem && !bus.mem_ready && !timeout && (state_d == state_q))
      wait_d = wait_q + CW'(1);
  end

  always_comb begin
    state_d        = state_q;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 2'd0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'd0;
    bus.alu_op     = '0;
    bus.illegal_op = 1'b0;
    bus.mem_err    = 1'b0;
    bus.instr_done = 1'b0;
    bus.state      = state_q;

    unique case (state_q)
      FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = 2'd1;
        bus.alu_op    = ALUOP_ADD;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = DECODE;
        end else if (timeout) begin
          bus.mem_err = 1'b1;
        end
      end
      DECODE: begin
        bus.alu_src_b = 2'd3;
        bus.alu_op    = ALUOP_ADD;
        case (bus.opcode)
          6'h00:                      state_d = R_EXE;
          6'h23, 6'h2B:               state_d = MEM_ADDR;
          6'h04, 6'h05:               state_d = BRANCH;
          6'h08, 6'h0A, 6'h0C, 6'h0D: state_d = I_EXE;
          6'h02:                      state_d = JUMP;
          default:                    state_d = ILLEGAL;
        endcase
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'd2;
        bus.alu_op    = ALUOP_ADD;
        state_d       = (bus.opcode == 6'h23) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) begin
          state_d = MEM_WB;
        end else if (timeout) begin
          bus.mem_err = 1'b1;
          state_d     = FETCH;
        end
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end
      MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) begin
          bus.instr_done = 1'b1;
          state_d        = FETCH;
        end else if (timeout) begin
          bus.mem_err = 1'b1;
          state_d     = FETCH;
        end
      end
      R_EXE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = bus.opcode;
        state_d       = R_WB;
      end
      R_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end
      I_EXE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'd2;
        bus.alu_op    = bus.opcode;
        state_d       = I_WB;
      end
      I_WB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_op     = ALUOP_SUB;
        bus.pc_src     = 2'd1;
        bus.pc_write   = (bus.opcode == 6'h04) ? bus.alu_zero : !bus.alu_zero;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end
      JUMP: begin
        bus.pc_write   = 1'b1;
        bus.pc_src     = 2'd2;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end
      ILLEGAL: begin
        bus.illegal_op = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (!rst_n) begin
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.iord       = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.pc_src     = 2'd0;
      bus.reg_write  = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'd0;
      bus.alu_op     = '0;
      bus.illegal_op = 1'b0;
      bus.mem_err    = 1'b0;
      bus.instr_done = 1'b0;
      bus.state      = '0;
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
module tb_mips_mc_ctrl;

  localparam logic [5:0] ADD = 6'h08;
  localparam logic [5:0] SUB = 6'h04;
  localparam int         TO  = 16;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [5:0] alu_op;
    logic       illegal_op;
    logic       mem_err;
    logic       instr_done;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  obs_t exp_q[$];
  logic rdy_q[$];

  mips_mc_ctrl_if bus ();

  mips_mc_ctrl #(
    .ALUOP_ADD  (ADD),
    .ALUOP_SUB  (SUB),
    .MEM_TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  function automatic obs_t sample();
    obs_t o;
    o.st         = bus.state;
    o.mem_req    = bus.mem_req;
    o.mem_we     = bus.mem_we;
    o.iord       = bus.iord;
    o.ir_write   = bus.ir_write;
    o.pc_write   = bus.pc_write;
    o.pc_src     = bus.pc_src;
    o.reg_write  = bus.reg_write;
    o.reg_dst    = bus.reg_dst;
    o.mem_to_reg = bus.mem_to_reg;
    o.alu_src_a  = bus.alu_src_a;
    o.alu_src_b  = bus.alu_src_b;
    o.alu_op     = bus.alu_op;
    o.illegal_op = bus.illegal_op;
    o.mem_err    = bus.mem_err;
    o.instr_done = bus.instr_done;
    return o;
  endfunction

  // ---------------- reference model: expected per-cycle trace -------------
  function automatic obs_t blank(input logic [3:0] st);
    obs_t o = '0;
    o.st = st;
    return o;
  endfunction

  task automatic push(input obs_t o, input logic rdy);
    exp_q.push_back(o);
    rdy_q.push_back(rdy);
  endtask

  // A memory access: w stalled cycles, then the ready cycle, unless the
  // watchdog expires first on the TO-th stalled cycle.
  task automatic add_mem(input obs_t wait_o, input obs_t done_o,
                         input int unsigned w, output logic aborted);
    obs_t e;
    aborted = 1'b0;
    for (int unsigned i = 0; i < w; i++) begin
      if (i == TO - 1) begin
        e = wait_o;
        e.mem_err = 1'b1;
        push(e, 1'b0);
        aborted = 1'b1;
        return;
      end
      push(wait_o, 1'b0);
    end
    push(done_o, 1'b1);
  endtask

  task automatic play(input string tag);
    obs_t got;
    for (int i = 0; i < exp_q.size(); i++) begin
      bus.mem_ready = rdy_q[i];
      #1;
      got = sample();
      checks++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h required %h (state got %0d required %0d)",
                 tag, i, got, exp_q[i], got.st, exp_q[i].st);
      end
      @(posedge clk);
      #1;
    end
    exp_q.delete();
    rdy_q.delete();
  endtask

  // Build and check one whole instruction. fw/mw: stalled cycles in fetch /
  // in the data access.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic z,
                           input int unsigned fw, input int unsigned mw);
    obs_t w, d;
    logic ab;
    bus.opcode   = op;
    bus.alu_zero = z;

    w = blank(4'd0);
    w.mem_req = 1'b1; w.alu_src_b = 2'd1; w.alu_op = ADD;
    d = w;
    d.ir_write = 1'b1; d.pc_write = 1'b1;
    add_mem(w, d, fw, ab);
    if (!ab) begin
      d = blank(4'd1);
      d.alu_src_b = 2'd3; d.alu_op = ADD;
      push(d, 1'($urandom_range(0, 1)));
      if (op == 6'h00) begin
        d = blank(4'd6); d.alu_src_a = 1'b1; d.alu_op = op;
        push(d, 1'($urandom_range(0, 1)));
        d = blank(4'd7); d.reg_write = 1'b1; d.reg_dst = 1'b1; d.instr_done = 1'b1;
        push(d, 1'($urandom_range(0, 1)));
      end else if (op == 6'h23 || op == 6'h2B) begin
        d = blank(4'd2); d.alu_src_a = 1'b1; d.alu_src_b = 2'd2; d.alu_op = ADD;
        push(d, 1'($urandom_range(0, 1)));
        if (op == 6'h23) begin
          w = blank(4'd3); w.mem_req = 1'b1; w.iord = 1'b1;
          add_mem(w, w, mw, ab);
          if (!ab) begin
            d = blank(4'd4); d.reg_write = 1'b1; d.mem_to_reg = 1'b1; d.instr_done = 1'b1;
            push(d, 1'($urandom_range(0, 1)));
          end
        end else begin
          w = blank(4'd5); w.mem_req = 1'b1; w.mem_we = 1'b1; w.iord = 1'b1;
          d = w; d.instr_done = 1'b1;
          add_mem(w, d, mw, ab);
        end
      end else if (op == 6'h04 || op == 6'h05) begin
        d = blank(4'd10); d.alu_src_a = 1'b1; d.alu_op = SUB; d.pc_src = 2'd1;
        d.pc_write = (op == 6'h04) ? z : !z;
        d.instr_done = 1'b1;
        push(d, 1'($urandom_range(0, 1)));
      end else if (op == 6'h08 || op == 6'h0A || op == 6'h0C || op == 6'h0D) begin
        d = blank(4'd8); d.alu_src_a = 1'b1; d.alu_src_b = 2'd2; d.alu_op = op;
        push(d, 1'($urandom_range(0, 1)));
        d = blank(4'd9); d.reg_write = 1'b1; d.instr_done = 1'b1;
        push(d, 1'($urandom_range(0, 1)));
      end else if (op == 6'h02) begin
        d = blank(4'd11); d.pc_write = 1'b1; d.pc_src = 2'd2; d.instr_done = 1'b1;
        push(d, 1'($urandom_range(0, 1)));
      end else begin
        d = blank(4'd12); d.illegal_op = 1'b1; d.instr_done = 1'b1;
        push(d, 1'($urandom_range(0, 1)));
      end
    end
    play(tag);
  endtask

  // ---------------- scenarios --------------------------------------------
  task automatic test_reset();
    obs_t got;
    rst_n = 1'b0;
    bus.opcode = 6'h00; bus.alu_zero = 1'b1; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got = sample();
    checks++;
    if (got !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", got);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_r_type();
    run_instr("r_type_add", 6'h00, 1'b0, 0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait3", 6'h23, 1'b0, 0, 3);
  endtask

  task automatic test_branch();
    run_instr("beq_taken", 6'h04, 1'b1, 0, 0);
    run_instr("bne_not_taken", 6'h05, 1'b1, 0, 0);
    run_instr("bne_taken", 6'h05, 1'b0, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_3f", 6'h3F, 1'b0, 0, 0);
    run_instr("jump", 6'h02, 1'b0, 0, 0);
  endtask

  task automatic test_timeout();
    run_instr("sw_timeout", 6'h2B, 1'b0, 0, 40);
    run_instr("sw_ready_at_expiry", 6'h2B, 1'b0, 0, TO - 1);
    run_instr("lw_timeout", 6'h23, 1'b0, 0, TO);
    run_instr("fetch_timeout", 6'h00, 1'b0, TO + 3, 0);
    run_instr("refetch_after_timeout", 6'h0D, 1'b0, 1, 0);
  endtask

  task automatic test_reset_mid_access();
    obs_t got;
    bus.opcode = 6'h2B; bus.alu_zero = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);  // FETCH, DECODE, MEM_ADDR
    #1;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.state !== 4'd5 || bus.mem_we !== 1'b1) begin
      errors++;
      $display("FAIL mid_access_setup: state %0d mem_we %b required 5 1", bus.state, bus.mem_we);
    end
    rst_n = 1'b0;
    #1;
    got = sample();
    checks++;
    if (got !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_mid_access_outputs: got %h required 0", got);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Counter must also be clear: a 15-cycle stall in fetch may not expire.
    run_instr("after_reset_fetch", 6'h23, 1'b0, TO - 1, 0);
  endtask

  task automatic test_random();
    logic [5:0] legal [10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05,
                               6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h02};
    logic [5:0] op;
    int unsigned fw, mw;
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal[$urandom_range(0, 9)];
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 3);
      run_instr("random", op, 1'($urandom_range(0, 1)), fw, mw);
    end
  endtask

  initial begin
    bus.opcode    = '0;
    bus.alu_zero  = 1'b0;
    bus.mem_ready = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_r_type();
    test_lw_wait();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
